// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared constants and types for the instruction-fetch front end
// Purpose: next-PC select encodings, fetch FSM state type, instruction word size.
// Ports: none (package).
package pc_pkg;

  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_J   = 2'b10;
  localparam logic [1:0] PC_SEL_REG = 2'b11;

  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_HOLD = 2'b10
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - redirect, instruction-memory and decode-side signal bundle
// Purpose: groups every non-clock/reset signal of pc_fetch_unit.
// Modports:
//   master - the fetch unit: drives imem_req/imem_addr and if_valid/if_pc/if_instr
//   slave  - its environment: drives redirects, memory responses and if_ready
interface pc_fetch_unit_if;
  logic        redir_valid;
  logic [1:0]  redir_sel;
  logic [31:0] redir_base_pc;
  logic [15:0] redir_imm;
  logic [25:0] redir_idx;
  logic [31:0] redir_rs;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;

  modport master (
    input  redir_valid, redir_sel, redir_base_pc, redir_imm, redir_idx, redir_rs,
    input  imem_ack, imem_rdata, if_ready,
    output imem_req, imem_addr, if_valid, if_pc, if_instr
  );

  modport slave (
    output redir_valid, redir_sel, redir_base_pc, redir_imm, redir_idx, redir_rs,
    output imem_ack, imem_rdata, if_ready,
    input  imem_req, imem_addr, if_valid, if_pc, if_instr
  );
endinterface

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational redirect target computation
// Purpose: 4:1 select of sequential / branch / jump / register target.
// Ports:
//   sel    in  2   select code (PC_SEL_*)
//   base   in  32  PC of the redirecting instruction
//   imm    in  16  signed branch offset in words
//   idx    in  26  jump index
//   rs     in  32  register target
//   target out 32  word-aligned redirect target
module next_pc_calc
  import pc_pkg::*;
(
  input  logic [1:0]  sel,
  input  logic [31:0] base,
  input  logic [15:0] imm,
  input  logic [25:0] idx,
  input  logic [31:0] rs,
  output logic [31:0] target
);

  logic [31:0] p4;
  logic [31:0] br_off;

  assign p4     = base + WORD_BYTES;
  // Word offset converted to bytes; sign extension makes the add wrap for backward branches.
  assign br_off = {{14{imm[15]}}, imm, 2'b00};

  always_comb begin
    target = p4;
    case (sel)
      PC_SEL_SEQ: target = p4;
      PC_SEL_BR:  target = p4 + br_off;
      PC_SEL_J:   target = {p4[31:28], idx, 2'b00};
      PC_SEL_REG: target = {rs[31:2], 2'b00};
      default:    target = p4;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register, imem req/ack fetch FSM and decode-side output hold
// Purpose: fetches one instruction at a time and hands it to decode with valid/ready;
//   redirects from decode reload the PC, discarding any in-flight or held word.
// Ports:
//   clk  in   1   rising-edge clock
//   rst  in   1   asynchronous active-high reset
//   bus  master modport of pc_fetch_unit_if (redirect, imem, decode handshake)
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
  input  logic           clk,
  input  logic           rst,
  pc_fetch_unit_if.master bus
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         pend;
  logic [31:0]  pend_pc;
  logic         imem_req_q;
  logic [31:0]  imem_addr_q;
  logic         if_valid_q;
  logic [31:0]  if_pc_q;
  logic [31:0]  if_instr_q;
  logic [31:0]  target;
  logic [31:0]  refetch_pc;

  next_pc_calc u_next_pc_calc (
    .sel    (bus.redir_sel),
    .base   (bus.redir_base_pc),
    .imm    (bus.redir_imm),
    .idx    (bus.redir_idx),
    .rs     (bus.redir_rs),
    .target (target)
  );

  // A redirect arriving together with the ack is newer than any parked one.
  assign refetch_pc = bus.redir_valid ? target : pend_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      pend        <= 1'b0;
      pend_pc     <= 32'h0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= 32'h0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= 32'h0;
      if_instr_q  <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          imem_req_q  <= 1'b1;
          imem_addr_q <= pc;
          state       <= S_REQ;
        end
        S_REQ: begin
          if (bus.imem_ack) begin
            if (pend || bus.redir_valid) begin
              // Returned word belongs to a squashed path: drop it and refetch.
              pc          <= refetch_pc;
              imem_addr_q <= refetch_pc;
              pend        <= 1'b0;
            end else begin
              if_instr_q <= bus.imem_rdata;
              if_pc_q    <= pc;
              if_valid_q <= 1'b1;
              pc         <= pc + WORD_BYTES;
              imem_req_q <= 1'b0;
              state      <= S_HOLD;
            end
          end else if (bus.redir_valid) begin
            // Address must stay stable until ack, so park the redirect.
            pend    <= 1'b1;
            pend_pc <= target;
          end
        end
        S_HOLD: begin
          if (bus.redir_valid) begin
            if_valid_q  <= 1'b0;
            pc          <= target;
            imem_addr_q <= target;
            imem_req_q  <= 1'b1;
            state       <= S_REQ;
          end else if (bus.if_ready) begin
            if_valid_q  <= 1'b0;
            imem_addr_q <= pc;
            imem_req_q  <= 1'b1;
            state       <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = imem_addr_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_instr  = if_instr_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for pc_fetch_unit
module tb_pc_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_fetch_unit_if bus();

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int credits  = 0;
  int ack_delay = 1;
  logic [31:0] exp_addr_q[$];
  out_t        exp_out_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    $display("FAIL %s: timed out, got no event expected one", name);
  endtask

  task automatic push_out(input logic [31:0] pc);
    out_t e;
    e.pc    = pc;
    e.instr = mem_word(pc);
    exp_out_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic redirect(input logic [1:0] sel, input logic [31:0] base, input logic [15:0] imm,
                          input logic [25:0] idx, input logic [31:0] rs);
    bus.redir_valid   = 1'b1;
    bus.redir_sel     = sel;
    bus.redir_base_pc = base;
    bus.redir_imm     = imm;
    bus.redir_idx     = idx;
    bus.redir_rs      = rs;
    tick();
    bus.redir_valid   = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (credits == 0 && !bus.imem_ack && exp_out_q.size() == 0 && bus.imem_req) return;
      tick();
    end
    fail_timeout(name);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 200; i++) begin
      if (bus.if_valid) return;
      tick();
    end
    fail_timeout(name);
  endtask

  // Memory model: acks after ack_delay extra cycles of request, only while credits remain;
  // checks every acked address against the scoreboard and address stability while waiting.
  initial begin
    int cnt;
    logic prev_req, prev_ack;
    logic [31:0] prev_addr;
    cnt = 0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'h0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.imem_req && prev_req && !prev_ack)
        check32("addr_stable", bus.imem_addr, prev_addr);
      prev_req  = bus.imem_req;
      prev_addr = bus.imem_addr;
      if (bus.imem_ack) begin
        bus.imem_ack = 1'b0;
        cnt = 0;
      end else if (bus.imem_req && credits > 0 && !rst) begin
        cnt++;
        if (cnt > ack_delay) begin
          if (exp_addr_q.size() == 0) begin
            n_checks++;
            $display("FAIL fetch_addr: got unexpected fetch %h expected none", bus.imem_addr);
          end else begin
            check32("fetch_addr", bus.imem_addr, exp_addr_q.pop_front());
          end
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = mem_word(bus.imem_addr);
          credits--;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
      prev_ack = bus.imem_ack;
    end
  end

  // Decode-side monitor: every transfer must match the next expected word.
  initial begin
    out_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.if_valid && bus.if_ready) begin
        if (exp_out_q.size() == 0) begin
          n_checks++;
          $display("FAIL if_transfer: got unexpected pc %h expected none", bus.if_pc);
        end else begin
          e = exp_out_q.pop_front();
          check32("if_pc", bus.if_pc, e.pc);
          check32("if_instr", bus.if_instr, e.instr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.redir_valid = 1'b0; bus.redir_sel = 2'b00; bus.redir_base_pc = 32'h0;
    bus.redir_imm = 16'h0; bus.redir_idx = 26'h0; bus.redir_rs = 32'h0;
    bus.if_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check32("rst_imem_req",  {31'h0, bus.imem_req}, 32'h0);
    check32("rst_imem_addr", bus.imem_addr, 32'h0);
    check32("rst_if_valid",  {31'h0, bus.if_valid}, 32'h0);
    check32("rst_if_pc",     bus.if_pc, 32'h0);
    check32("rst_if_instr",  bus.if_instr, 32'h0);

    // 1: sequential fetch from reset
    for (int i = 0; i < 4; i++) begin
      exp_addr_q.push_back(32'(i * 4));
      push_out(32'(i * 4));
    end
    credits = 4;
    rst = 1'b0;
    #1;
    check32("req_low_after_rst", {31'h0, bus.imem_req}, 32'h0);
    tick();
    check32("first_req", {31'h0, bus.imem_req}, 32'h1);
    check32("first_addr", bus.imem_addr, 32'h0);
    wait_drain("t1_seq");
    check32("t1_next_addr", bus.imem_addr, 32'h10);

    // 1b: wrap from 0xFFFF_FFFC, low rs bits forced to zero
    redirect(2'b11, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFFF);
    exp_addr_q.push_back(32'h10);
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0);
    push_out(32'hFFFF_FFFC);
    push_out(32'h0);
    credits = 3;
    wait_drain("t1_wrap");
    check32("t1_wrap_next", bus.imem_addr, 32'h4);

    // move to 0x10
    redirect(2'b11, 32'h0, 16'h0, 26'h0, 32'h10);
    exp_addr_q.push_back(32'h4);
    credits = 1;
    wait_drain("t3_setup");
    check32("t3_start_addr", bus.imem_addr, 32'h10);

    // 3: delayed ack, jump redirect mid-wait
    ack_delay = 3;
    exp_addr_q.push_back(32'h10);
    credits = 1;
    tick();
    redirect(2'b10, 32'h3000_0000, 16'h0, 26'h40, 32'h0);
    wait_drain("t3_jump");
    check32("t3_jump_addr", bus.imem_addr, 32'h3000_0100);
    check32("t3_no_valid", {31'h0, bus.if_valid}, 32'h0);

    // 5: stall in HOLD
    ack_delay = 1;
    bus.if_ready = 1'b0;
    exp_addr_q.push_back(32'h3000_0100);
    credits = 1;
    wait_valid("t5_hold");
    for (int i = 0; i < 5; i++) begin
      tick();
      check32("t5_valid", {31'h0, bus.if_valid}, 32'h1);
      check32("t5_pc", bus.if_pc, 32'h3000_0100);
      check32("t5_instr", bus.if_instr, mem_word(32'h3000_0100));
      check32("t5_req", {31'h0, bus.imem_req}, 32'h0);
    end

    // 2: branch redirect from HOLD, held word discarded
    redirect(2'b01, 32'h100, 16'hFFFE, 26'h0, 32'h0);
    check32("t2_valid_fall", {31'h0, bus.if_valid}, 32'h0);
    check32("t2_req", {31'h0, bus.imem_req}, 32'h1);
    check32("t2_addr", bus.imem_addr, 32'h0000_00FC);
    bus.if_ready = 1'b1;
    exp_addr_q.push_back(32'hFC);
    push_out(32'hFC);
    credits = 1;
    wait_drain("t2_fetch");
    check32("t2_next_addr", bus.imem_addr, 32'h100);

    // 4: two redirects in one wait, latest wins
    redirect(2'b11, 32'h0, 16'h0, 26'h0, 32'h203);
    redirect(2'b00, 32'h50, 16'h0, 26'h0, 32'h0);
    exp_addr_q.push_back(32'h100);
    exp_addr_q.push_back(32'h54);
    push_out(32'h54);
    credits = 2;
    wait_drain("t4_double");
    check32("t4_next_addr", bus.imem_addr, 32'h58);

    // 6: reset during an outstanding request with a parked redirect
    redirect(2'b11, 32'h0, 16'h0, 26'h0, 32'h800);
    rst = 1'b1;
    #1;
    check32("t6_req_drop", {31'h0, bus.imem_req}, 32'h0);
    check32("t6_valid_drop", {31'h0, bus.if_valid}, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check32("t6_req_rise", {31'h0, bus.imem_req}, 32'h1);
    check32("t6_addr", bus.imem_addr, 32'h0);
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    push_out(32'h0);
    push_out(32'h4);
    credits = 2;
    wait_drain("t6_refetch");
    check32("t6_next_addr", bus.imem_addr, 32'h8);

    check32("addr_q_empty", 32'(exp_addr_q.size()), 32'h0);
    check32("out_q_empty", 32'(exp_out_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
